sprite_motion_ctrl: RTL and testbench

SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

---
 rtl/sprite_motion_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl.sv
// Bouncing-box position and colour controller. Position and colour commit once
// every FRAME_DIV vertical-sync rising edges through a WAIT/CALC/COMMIT sequencer.
module sprite_motion_ctrl #(
  parameter int H_ACTIVE  = 800,
  parameter int V_ACTIVE  = 480,
  parameter int BOX_W     = 70,
  parameter int BOX_H     = 70,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1,
  parameter int DEB_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        run,
  input  logic [2:0]  sw,
  output logic [15:0] box_x,
  output logic [15:0] box_y,
  output logic [11:0] box_rgb,
  output logic        dir_x,
  output logic        dir_y,
  output logic        upd
);

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [11:0] RGB_RED   = 12'hF00;
  localparam logic [11:0] RGB_GREEN = 12'h0F0;
  localparam logic [11:0] RGB_BLUE  = 12'h00F;

  typedef enum logic [1:0] {WAIT, CALC, COMMIT} state_t;

  state_t       state_reg, state_next;
  logic [15:0]  fcnt_reg, fcnt_next;
  logic [16:0]  fcnt_sum;

  logic [1:0]   vs_sync_reg;
  logic         vs_prev_reg;
  logic         frame_tick;
  logic [2:0]   sw_s1_reg, sw_s2_reg;
  logic [2:0]   press;
  logic [11:0]  rgb_pend_reg;

  logic [15:0]  box_x_reg, box_y_reg, nx_reg, ny_reg;
  logic         dir_x_reg, dir_y_reg, ndx_reg, ndy_reg;
  logic [11:0]  box_rgb_reg, nrgb_reg;
  logic [16:0]  x_step, y_step;

  // One axis of motion: advance by STEP, clamp to the far edge and reverse.
  function automatic logic [16:0] axis_next(input logic [15:0] pos, input logic dir,
                                            input logic [16:0] extent, input logic [16:0] size);
    logic [16:0] p;
    logic [16:0] fwd;
    logic [15:0] np;
    logic        nd;
    p   = {1'b0, pos};
    fwd = p + 17'(STEP);
    np  = pos;
    nd  = dir;
    if (!dir) begin
      if (fwd + size >= extent) begin
        np = 16'(extent - size);
        nd = 1'b1;
      end else begin
        np = 16'(fwd);
      end
    end else if (p <= 17'(STEP)) begin
      np = 16'd0;
      nd = 1'b0;
    end else begin
      np = 16'(p - 17'(STEP));
    end
    return {nd, np};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vs_sync_reg <= 2'b00;
      vs_prev_reg <= 1'b0;
      sw_s1_reg   <= 3'b000;
      sw_s2_reg   <= 3'b000;
    end else begin
      vs_sync_reg <= {vs_sync_reg[0], vsync};
      vs_prev_reg <= vs_sync_reg[1];
      sw_s1_reg   <= sw;
      sw_s2_reg   <= sw_s1_reg;
    end
  end

  assign frame_tick = vs_sync_reg[1] & ~vs_prev_reg;

  // Counter saturates at DEB_CYC, so a held button yields a single event.
  for (genvar gi = 0; gi < 3; gi++) begin : g_deb
    logic [DW-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (sw_s2_reg[gi]) begin
        cnt_reg <= '0;
      end else if (cnt_reg != DW'(DEB_CYC)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign press[gi] = ~sw_s2_reg[gi] && (cnt_reg == DW'(DEB_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_pend_reg <= RGB_GREEN;
    end else if (press[0]) begin
      rgb_pend_reg <= RGB_RED;
    end else if (press[1]) begin
      rgb_pend_reg <= RGB_GREEN;
    end else if (press[2]) begin
      rgb_pend_reg <= RGB_BLUE;
    end
  end

  // Ticks are accumulated in every state; a surplus left over from CALC/COMMIT
  // starts the next update as soon as the sequencer is back in WAIT.
  always_comb begin
    state_next = state_reg;
    fcnt_sum   = {1'b0, fcnt_reg} + 17'(frame_tick);
    fcnt_next  = fcnt_sum[15:0];
    case (state_reg)
      WAIT: begin
        if (fcnt_sum >= 17'(FRAME_DIV)) begin
          fcnt_next  = 16'(fcnt_sum - 17'(FRAME_DIV));
          state_next = CALC;
        end
      end
      CALC:    state_next = COMMIT;
      COMMIT:  state_next = WAIT;
      default: state_next = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= WAIT;
      fcnt_reg  <= 16'd0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
    end
  end

  assign x_step = axis_next(box_x_reg, dir_x_reg, 17'(H_ACTIVE), 17'(BOX_W));
  assign y_step = axis_next(box_y_reg, dir_y_reg, 17'(V_ACTIVE), 17'(BOX_H));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nx_reg   <= 16'd2;
      ny_reg   <= 16'd2;
      ndx_reg  <= 1'b0;
      ndy_reg  <= 1'b0;
      nrgb_reg <= RGB_GREEN;
    end else if (state_reg == CALC) begin
      nrgb_reg <= rgb_pend_reg;
      if (run) begin
        nx_reg  <= x_step[15:0];
        ndx_reg <= x_step[16];
        ny_reg  <= y_step[15:0];
        ndy_reg <= y_step[16];
      end else begin
        nx_reg  <= box_x_reg;
        ndx_reg <= dir_x_reg;
        ny_reg  <= box_y_reg;
        ndy_reg <= dir_y_reg;
      end
    end
  end

  // Visible outputs move only as COMMIT completes, never mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_x_reg   <= 16'd2;
      box_y_reg   <= 16'd2;
      dir_x_reg   <= 1'b0;
      dir_y_reg   <= 1'b0;
      box_rgb_reg <= RGB_GREEN;
    end else if (state_reg == COMMIT) begin
      box_x_reg   <= nx_reg;
      box_y_reg   <= ny_reg;
      dir_x_reg   <= ndx_reg;
      dir_y_reg   <= ndy_reg;
      box_rgb_reg <= nrgb_reg;
    end
  end

  assign box_x   = box_x_reg;
  assign box_y   = box_y_reg;
  assign dir_x   = dir_x_reg;
  assign dir_y   = dir_y_reg;
  assign box_rgb = box_rgb_reg;
  assign upd     = (state_reg == COMMIT);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: directed and randomized frames checked against
// a behavioural bouncing-box and colour model.
module tb_sprite_motion_ctrl;
  localparam int H = 800, V = 480, BW = 70, BH = 70, STEP = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vsync = 1'b0, run = 1'b1;
  logic [2:0] sw = 3'b111;
  logic [15:0] box_x, box_y;
  logic [11:0] box_rgb;
  logic dir_x, dir_y, upd;

  logic vsync3 = 1'b0, run3 = 1'b0;
  logic [2:0] sw3 = 3'b111;
  logic [15:0] box_x3, box_y3;
  logic [11:0] box_rgb3;
  logic dir_x3, dir_y3, upd3;

  int n_err = 0, n_chk = 0;
  int mx, my;
  bit mdx, mdy;
  logic [11:0] mrgb, mpend;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk(clk), .rst(rst), .vsync(vsync), .run(run), .sw(sw),
    .box_x(box_x), .box_y(box_y), .box_rgb(box_rgb),
    .dir_x(dir_x), .dir_y(dir_y), .upd(upd)
  );

  sprite_motion_ctrl #(.FRAME_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .vsync(vsync3), .run(run3), .sw(sw3),
    .box_x(box_x3), .box_y(box_y3), .box_rgb(box_rgb3),
    .dir_x(dir_x3), .dir_y(dir_y3), .upd(upd3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bouncing motion on one axis, from the box's extent and the screen size.
  function automatic void model_axis(inout int p, inout bit d, input int ext, input int sz);
    int far_edge;
    far_edge = ext - sz;
    if (!d) begin
      p = p + STEP;
      if (p >= far_edge) begin p = far_edge; d = 1'b1; end
    end else begin
      p = (p <= STEP) ? 0 : p - STEP;
      if (p == 0) d = 1'b0;
    end
  endfunction

  task automatic model_reset();
    mx = 2; my = 2; mdx = 1'b0; mdy = 1'b0; mrgb = 12'h0F0; mpend = 12'h0F0;
  endtask

  task automatic frame(input int gap);
    int lat;
    lat = 0;
    vsync = 1'b1;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(negedge clk);
      if (upd) lat = i;
    end
    chk("upd_latency", lat, 4);
    if (run) begin
      model_axis(mx, mdx, H, BW);
      model_axis(my, mdy, V, BH);
    end
    mrgb = mpend;
    @(negedge clk);
    chk("upd_width", upd, 0);
    chk("box_x", box_x, mx);
    chk("box_y", box_y, my);
    chk("dir_x", dir_x, mdx);
    chk("dir_y", dir_y, mdy);
    chk("box_rgb", box_rgb, mrgb);
    chk("x_bound", box_x <= 16'(H - BW), 1);
    chk("y_bound", box_y <= 16'(V - BH), 1);
    $display("frame run=%0d x=%0d y=%0d dx=%0d dy=%0d rgb=%h", run, box_x, box_y, dir_x, dir_y, box_rgb);
    vsync = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, input int n);
    sw = ~mask;
    repeat (n) @(negedge clk);
    sw = 3'b111;
    repeat (4) @(negedge clk);
    if (n >= 20) begin
      if (mask[0]) mpend = 12'hF00;
      else if (mask[1]) mpend = 12'h0F0;
      else if (mask[2]) mpend = 12'h00F;
    end
    $display("press mask=%b cycles=%0d pending_model=%h", mask, n, mpend);
  endtask

  task automatic pulse3(input int exp_upd);
    int cnt;
    cnt = 0;
    vsync3 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (upd3) cnt++;
    end
    vsync3 = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (upd3) cnt++;
    end
    chk("fdiv3_upd_count", cnt, exp_upd);
    $display("div3 tick upd_pulses=%0d x=%0d y=%0d", cnt, box_x3, box_y3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    logic [2:0] m;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_box_x", box_x, 2);
    chk("rst_box_y", box_y, 2);
    chk("rst_dir_x", dir_x, 0);
    chk("rst_dir_y", dir_y, 0);
    chk("rst_rgb", box_rgb, 12'h0F0);
    chk("rst_upd", upd, 0);
    chk("rst_upd3", upd3, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Three consecutive frames from reset.
    for (int k = 0; k < 3; k++) begin
      frame(4);
      chk("seq_x", box_x, 3 + k);
      chk("seq_y", box_y, 3 + k);
      chk("seq_rgb", box_rgb, 12'h0F0);
    end

    // Short press rejected, long press accepted but held until commit.
    press(3'b100, 10);
    frame(4);
    chk("short_press_rgb", box_rgb, 12'h0F0);
    press(3'b100, 20);
    chk("rgb_before_commit", box_rgb, 12'h0F0);
    frame(4);
    chk("blue_rgb", box_rgb, 12'h00F);
    press(3'b011, 20);
    frame(4);
    chk("priority_rgb", box_rgb, 12'hF00);

    // FRAME_DIV=3 with motion disabled.
    for (int k = 0; k < 6; k++) pulse3((k % 3 == 2) ? 1 : 0);
    chk("div3_x", box_x3, 2);
    chk("div3_y", box_y3, 2);
    chk("div3_rgb", box_rgb3, 12'h0F0);

    // Randomized run/press/frame spacing.
    for (int k = 0; k < 60; k++) begin
      run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        m = 3'($urandom_range(1, 7));
        press(m, ($urandom_range(0, 1) == 1) ? $urandom_range(4, 10) : $urandom_range(20, 30));
      end
      frame($urandom_range(3, 6));
    end

    // Right edge.
    run = 1'b1;
    guard = 0;
    while (!(mx == 729 && mdx == 1'b0) && guard < 3000) begin frame(3); guard++; end
    chk("at_729_x", box_x, 729);
    chk("at_729_dir", dir_x, 0);
    frame(3);
    chk("right_edge_x", box_x, 730);
    chk("right_edge_dir", dir_x, 1);
    frame(3);
    chk("right_back_x", box_x, 729);

    // Left edge.
    while (!(mx == 1 && mdx == 1'b1) && guard < 6000) begin frame(3); guard++; end
    chk("at_1_x", box_x, 1);
    chk("at_1_dir", dir_x, 1);
    frame(3);
    chk("left_edge_x", box_x, 0);
    chk("left_edge_dir", dir_x, 0);
    frame(3);
    chk("left_back_x", box_x, 1);

    // Leave two ticks pending in the divide-by-3 instance before reset.
    pulse3(0);
    pulse3(0);

    // Reset during CALC aborts the update.
    vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("calc_no_upd", upd, 0);
    rst = 1'b0;
    vsync = 1'b0;
    #1;
    chk("abort_x", box_x, 2);
    chk("abort_y", box_y, 2);
    chk("abort_rgb", box_rgb, 12'h0F0);
    chk("abort_upd", upd, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    begin
      int cnt;
      cnt = 0;
      repeat (10) begin
        @(negedge clk);
        if (upd) cnt++;
      end
      chk("abort_no_upd", cnt, 0);
    end
    chk("post_x", box_x, 2);
    chk("post_y", box_y, 2);
    chk("post_dir_x", dir_x, 0);
    chk("post_dir_y", dir_y, 0);
    chk("post_rgb", box_rgb, 12'h0F0);

    // Fresh frame count after reset.
    pulse3(0);
    pulse3(0);
    pulse3(1);
    frame(4);
    chk("first_after_rst_x", box_x, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
